// File: rtl/ram_march_bist_pkg.sv
// Shared constants for the March C- (reduced) RAM self-test: default geometry
// and the state encoding of the test sequencer.
`default_nettype none

package ram_march_bist_pkg;

  localparam int DEF_ADDR_WIDTH = 9;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 512;

  localparam int STATE_WIDTH = 4;

  localparam logic [STATE_WIDTH-1:0] ST_IDLE  = 4'd0;
  localparam logic [STATE_WIDTH-1:0] ST_M0    = 4'd1;
  localparam logic [STATE_WIDTH-1:0] ST_M1_R  = 4'd2;
  localparam logic [STATE_WIDTH-1:0] ST_M1_W  = 4'd3;
  localparam logic [STATE_WIDTH-1:0] ST_M2_R  = 4'd4;
  localparam logic [STATE_WIDTH-1:0] ST_M2_W  = 4'd5;
  localparam logic [STATE_WIDTH-1:0] ST_M3    = 4'd6;
  localparam logic [STATE_WIDTH-1:0] ST_DRAIN = 4'd7;
  localparam logic [STATE_WIDTH-1:0] ST_DONE  = 4'd8;

endpackage

`default_nettype wire

// File: rtl/ram_bist_checker.sv
// Read-data checker: one-stage expect/address pipeline aligned with the RAM's
// read latency, first-failure capture and a saturating mismatch counter.
`default_nettype none

module ram_bist_checker #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  chk_valid,
  input  logic [ADDR_WIDTH-1:0] chk_addr,
  input  logic [DATA_WIDTH-1:0] chk_exp,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_exp,
  output logic [DATA_WIDTH-1:0] fail_got,
  output logic [7:0]            err_count,
  output logic                  clean_next
);

  logic                  pipe_valid;
  logic [ADDR_WIDTH-1:0] pipe_addr;
  logic [DATA_WIDTH-1:0] pipe_exp;
  logic                  mismatch;

  assign mismatch   = pipe_valid && (rd_data != pipe_exp);
  // Lets the sequencer latch pass in the same edge as the final comparison.
  assign clean_next = (err_count == 8'd0) && !mismatch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid <= 1'b0;
      pipe_addr  <= '0;
      pipe_exp   <= '0;
      fail_addr  <= '0;
      fail_exp   <= '0;
      fail_got   <= '0;
      err_count  <= 8'd0;
    end else if (clear) begin
      pipe_valid <= 1'b0;
      pipe_addr  <= '0;
      pipe_exp   <= '0;
      fail_addr  <= '0;
      fail_exp   <= '0;
      fail_got   <= '0;
      err_count  <= 8'd0;
    end else begin
      pipe_valid <= chk_valid;
      pipe_addr  <= chk_addr;
      pipe_exp   <= chk_exp;
      if (mismatch) begin
        // The counter saturates, so zero means no earlier failure was seen.
        if (err_count == 8'd0) begin
          fail_addr <= pipe_addr;
          fail_exp  <= pipe_exp;
          fail_got  <= rd_data;
        end
        if (err_count != 8'hFF) begin
          err_count <= err_count + 8'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_march_bist.sv
// March C- (reduced) BIST sequencer for a synchronous dual-port RAM; every
// RAM-side output is registered from the next-state decode.
`default_nettype none

module ram_march_bist
  import ram_march_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] PATTERN = DATA_WIDTH'('h55)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  wr_enb,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_enb,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_exp,
  output logic [DATA_WIDTH-1:0] fail_got,
  output logic [7:0]            err_count
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [DATA_WIDTH-1:0] PATTERN_N = ~PATTERN;

  logic [STATE_WIDTH-1:0] state;
  logic [STATE_WIDTH-1:0] next_state;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [ADDR_WIDTH-1:0]  next_addr;
  logic                   start_test;

  logic                  nx_wr_enb;
  logic [ADDR_WIDTH-1:0] nx_wr_addr;
  logic [DATA_WIDTH-1:0] nx_wr_data;
  logic                  nx_rd_enb;
  logic [ADDR_WIDTH-1:0] nx_rd_addr;
  logic [DATA_WIDTH-1:0] nx_rd_exp;
  logic                  nx_busy;
  logic [DATA_WIDTH-1:0] rd_exp;
  logic                  clean_next;

  assign start_test = (state == ST_IDLE) && start;

  always_comb begin
    next_state = state;
    next_addr  = addr;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = ST_M0;
          next_addr  = '0;
        end
      end
      ST_M0: begin
        if (addr == LAST_ADDR) begin
          next_state = ST_M1_R;
          next_addr  = '0;
        end else begin
          next_addr = addr + 1'b1;
        end
      end
      ST_M1_R: next_state = ST_M1_W;
      ST_M1_W: begin
        if (addr == LAST_ADDR) begin
          next_state = ST_M2_R;
          next_addr  = LAST_ADDR;
        end else begin
          next_state = ST_M1_R;
          next_addr  = addr + 1'b1;
        end
      end
      ST_M2_R: next_state = ST_M2_W;
      ST_M2_W: begin
        // Terminal test on zero keeps the descending count from underflowing.
        if (addr == '0) begin
          next_state = ST_M3;
          next_addr  = '0;
        end else begin
          next_state = ST_M2_R;
          next_addr  = addr - 1'b1;
        end
      end
      ST_M3: begin
        if (addr == LAST_ADDR) begin
          next_state = ST_DRAIN;
        end else begin
          next_addr = addr + 1'b1;
        end
      end
      ST_DRAIN: next_state = ST_DONE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // RAM command decode for the cycle the FSM is about to enter.
  always_comb begin
    nx_wr_enb  = 1'b0;
    nx_wr_addr = '0;
    nx_wr_data = '0;
    nx_rd_enb  = 1'b0;
    nx_rd_addr = '0;
    nx_rd_exp  = '0;
    case (next_state)
      ST_M0, ST_M2_W: begin
        nx_wr_enb  = 1'b1;
        nx_wr_addr = next_addr;
        nx_wr_data = PATTERN;
      end
      ST_M1_W: begin
        nx_wr_enb  = 1'b1;
        nx_wr_addr = next_addr;
        nx_wr_data = PATTERN_N;
      end
      ST_M1_R, ST_M3: begin
        nx_rd_enb  = 1'b1;
        nx_rd_addr = next_addr;
        nx_rd_exp  = PATTERN;
      end
      ST_M2_R: begin
        nx_rd_enb  = 1'b1;
        nx_rd_addr = next_addr;
        nx_rd_exp  = PATTERN_N;
      end
      default: ;
    endcase
    nx_busy = (next_state != ST_IDLE) && (next_state != ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      addr    <= '0;
      wr_enb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      rd_enb  <= 1'b0;
      rd_addr <= '0;
      rd_exp  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else begin
      state   <= next_state;
      addr    <= next_addr;
      wr_enb  <= nx_wr_enb;
      wr_addr <= nx_wr_addr;
      wr_data <= nx_wr_data;
      rd_enb  <= nx_rd_enb;
      rd_addr <= nx_rd_addr;
      rd_exp  <= nx_rd_exp;
      busy    <= nx_busy;
      done    <= (next_state == ST_DONE);
      if (start_test) begin
        pass <= 1'b0;
      end else if (next_state == ST_DONE) begin
        pass <= clean_next;
      end
    end
  end

  ram_bist_checker #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_checker (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_test),
    .chk_valid  (rd_enb),
    .chk_addr   (rd_addr),
    .chk_exp    (rd_exp),
    .rd_data    (rd_data),
    .fail_addr  (fail_addr),
    .fail_exp   (fail_exp),
    .fail_got   (fail_got),
    .err_count  (err_count),
    .clean_next (clean_next)
  );

endmodule

`default_nettype wire

// File: tb/tb_ram_march_bist.sv
// Bench for ram_march_bist: behavioural RAM with stuck-bit faults, a
// March C- reference model built from the algorithm's op list, and directed steps.
`default_nettype none

module tb_ram_march_bist;

  localparam logic [7:0] PAT  = 8'h55;
  localparam logic [7:0] NPAT = 8'hAA;
  localparam int         D    = 512;

  typedef struct {
    bit         wr;
    int         addr;
    logic [7:0] val;
  } op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start4 = 1'b0;

  logic       wr_enb, rd_enb, busy, done, pass;
  logic [8:0] wr_addr, rd_addr, fail_addr;
  logic [7:0] wr_data, fail_exp, fail_got, err_count;
  logic [7:0] rd_data = 8'h00;

  logic       wr_enb4, rd_enb4, busy4, done4, pass4;
  logic [1:0] wr_addr4, rd_addr4, fail_addr4;
  logic [7:0] wr_data4, fail_exp4, fail_got4, err_count4;
  logic [7:0] rd_data4 = 8'h00;

  logic [7:0] mem  [0:511];
  logic [7:0] mem4 [0:3];
  bit         fault_on = 1'b0;
  logic [8:0] fault_addr = 9'd0;
  logic [7:0] fault_sa0 = 8'h00;
  logic [7:0] fault_sa1 = 8'h00;

  int  checks = 0;
  int  failures = 0;
  int  overlap = 0;
  op_t march_q[$];

  always #5 clk = ~clk;

  ram_march_bist dut (
    .clk(clk), .rst(rst), .start(start),
    .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_enb(rd_enb), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_got(fail_got),
    .err_count(err_count)
  );

  ram_march_bist #(.ADDR_WIDTH(2), .DEPTH(4), .DATA_WIDTH(8), .PATTERN(8'h55)) dut4 (
    .clk(clk), .rst(rst), .start(start4),
    .wr_enb(wr_enb4), .wr_addr(wr_addr4), .wr_data(wr_data4),
    .rd_enb(rd_enb4), .rd_addr(rd_addr4), .rd_data(rd_data4),
    .busy(busy4), .done(done4), .pass(pass4),
    .fail_addr(fail_addr4), .fail_exp(fail_exp4), .fail_got(fail_got4),
    .err_count(err_count4)
  );

  // Stuck bits are applied on store, so every later read sees the faulty cell.
  always @(posedge clk) begin
    if (wr_enb)
      mem[wr_addr] <= (fault_on && wr_addr == fault_addr) ? ((wr_data & ~fault_sa0) | fault_sa1) : wr_data;
    if (rd_enb)
      rd_data <= mem[rd_addr];
    if (wr_enb4)
      mem4[wr_addr4] <= wr_data4;
    if (rd_enb4)
      rd_data4 <= mem4[rd_addr4];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // March C- reduced as an ordered list of RAM operations.
  function automatic void build_march(input int depth);
    march_q.delete();
    for (int a = 0; a < depth; a++) march_q.push_back('{wr: 1'b1, addr: a, val: PAT});
    for (int a = 0; a < depth; a++) begin
      march_q.push_back('{wr: 1'b0, addr: a, val: PAT});
      march_q.push_back('{wr: 1'b1, addr: a, val: NPAT});
    end
    for (int a = depth - 1; a >= 0; a--) begin
      march_q.push_back('{wr: 1'b0, addr: a, val: NPAT});
      march_q.push_back('{wr: 1'b1, addr: a, val: PAT});
    end
    for (int a = 0; a < depth; a++) march_q.push_back('{wr: 1'b0, addr: a, val: PAT});
  endfunction

  task automatic model_run(input int faddr, input logic [7:0] sa0, input logic [7:0] sa1,
                           output int errs, output int f_addr,
                           output logic [7:0] f_exp, output logic [7:0] f_got);
    logic [7:0] m [0:511];
    errs = 0; f_addr = 0; f_exp = 8'h00; f_got = 8'h00;
    build_march(D);
    foreach (march_q[i]) begin
      if (march_q[i].wr) begin
        m[march_q[i].addr] = (march_q[i].addr == faddr) ? ((march_q[i].val & ~sa0) | sa1) : march_q[i].val;
      end else if (m[march_q[i].addr] !== march_q[i].val) begin
        if (errs == 0) begin
          f_addr = march_q[i].addr;
          f_exp  = march_q[i].val;
          f_got  = m[march_q[i].addr];
        end
        if (errs < 255) errs++;
      end
    end
  endtask

  task automatic run_main(input int p1, input int p2,
                          output int nbusy, output int ndone, output int first_busy, output int span);
    int done_at;
    done_at = -1; first_busy = -1; nbusy = 0; ndone = 0; span = -1;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 8000; n++) begin
      @(negedge clk);
      if (busy) begin
        nbusy++;
        if (first_busy < 0) first_busy = n;
      end
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = n;
      end
      if (wr_enb && rd_enb && wr_addr == rd_addr) overlap++;
      start = (n == p1) || (n == p2);
      if (done_at >= 0 && n >= done_at + 3) break;
    end
    start = 1'b0;
    if (done_at >= 0 && first_busy >= 0) span = done_at - first_busy;
  endtask

  task automatic test_fault(input string tag, input bit fon, input int faddr,
                            input logic [7:0] sa0, input logic [7:0] sa1,
                            input int p1, input int p2);
    int errs, f_addr, nbusy, ndone, first_busy, span;
    logic [7:0] f_exp, f_got;
    fault_on = fon; fault_addr = 9'(faddr); fault_sa0 = sa0; fault_sa1 = sa1;
    if (fon) model_run(faddr, sa0, sa1, errs, f_addr, f_exp, f_got);
    else     model_run(-1, 8'h00, 8'h00, errs, f_addr, f_exp, f_got);
    run_main(p1, p2, nbusy, ndone, first_busy, span);
    check({tag, ".busy_cycles"}, 64'(nbusy), 64'(6 * D + 1));
    check({tag, ".first_busy"}, 64'(first_busy), 64'd1);
    check({tag, ".done_pulses"}, 64'(ndone), 64'd1);
    check({tag, ".span"}, 64'(span), 64'd3073);
    check({tag, ".pass"}, 64'(pass), 64'(errs == 0));
    check({tag, ".err_count"}, 64'(err_count), 64'(errs));
    check({tag, ".fail_addr"}, 64'(fail_addr), 64'(f_addr));
    check({tag, ".fail_exp"}, 64'(fail_exp), 64'(f_exp));
    check({tag, ".fail_got"}, 64'(fail_got), 64'(f_got));
  endtask

  task automatic run_small();
    int wq[$];
    int rq[$];
    int ew[$];
    int er[$];
    int first_busy, done_at;
    first_busy = -1; done_at = -1;
    @(negedge clk);
    start4 = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      start4 = 1'b0;
      if (wr_enb4) wq.push_back(int'(wr_addr4));
      if (rd_enb4) rq.push_back(int'(rd_addr4));
      if (busy4 && first_busy < 0) first_busy = n;
      if (done4 && done_at < 0) done_at = n;
      if (done_at >= 0) break;
    end
    build_march(4);
    foreach (march_q[i]) begin
      if (march_q[i].wr) ew.push_back(march_q[i].addr);
      else               er.push_back(march_q[i].addr);
    end
    // Each M1/M2 read is immediately followed by a write to the same address.
    check("d4.span", 64'((done_at >= 0 && first_busy >= 0) ? done_at - first_busy : -1), 64'd25);
    check("d4.pass", 64'(pass4), 64'd1);
    check("d4.err_count", 64'(err_count4), 64'd0);
    check("d4.wr_count", 64'(wq.size()), 64'(ew.size()));
    check("d4.rd_count", 64'(rq.size()), 64'(er.size()));
    for (int i = 0; i < ew.size() && i < wq.size(); i++)
      check($sformatf("d4.wr_addr[%0d]", i), 64'(wq[i]), 64'(ew[i]));
    for (int i = 0; i < er.size() && i < rq.size(); i++)
      check($sformatf("d4.rd_addr[%0d]", i), 64'(rq[i]), 64'(er[i]));
  endtask

  initial begin
    logic [7:0] msk, pol;
    #1;
    check("reset.outputs",
          64'({busy, done, pass, err_count, fail_addr, fail_exp, fail_got, wr_enb, wr_addr, wr_data, rd_enb, rd_addr}),
          64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle.busy", 64'(busy), 64'd0);

    test_fault("clean", 1'b0, 0, 8'h00, 8'h00, 0, 0);
    check("clean.fail_zero", 64'({fail_addr, fail_exp, fail_got}), 64'd0);

    test_fault("w55b0", 1'b1, 55, 8'h01, 8'h00, 0, 0);
    check("w55b0.spec_err", 64'(err_count), 64'd2);
    check("w55b0.spec_got", 64'(fail_got), 64'h54);

    test_fault("w300ff", 1'b1, 300, 8'h00, 8'hFF, 0, 0);
    check("w300ff.spec_err", 64'(err_count), 64'd3);

    for (int k = 0; k < 3; k++) begin
      msk = 8'($urandom_range(1, 255));
      pol = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      test_fault($sformatf("rand%0d", k), 1'b1, int'($urandom_range(0, D - 1)),
                 msk & ~pol, msk & pol, int'($urandom_range(2, 3000)), 0);
    end

    // Asynchronous reset in the middle of a test.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (999) @(negedge clk);
    check("midrst.busy_before", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst.outputs",
          64'({busy, done, pass, err_count, fail_addr, fail_exp, fail_got, wr_enb, wr_addr, wr_data, rd_enb, rd_addr}),
          64'd0);
    begin
      int dseen;
      dseen = 0;
      repeat (3) begin
        @(negedge clk);
        if (done) dseen++;
      end
      rst = 1'b0;
      repeat (4) begin
        @(negedge clk);
        if (done || busy) dseen++;
      end
      check("midrst.no_done", 64'(dseen), 64'd0);
    end
    test_fault("after_rst", 1'b0, 0, 8'h00, 8'h00, 0, 0);

    test_fault("restart_ignored", 1'b0, 0, 8'h00, 8'h00, 10, 2000);

    run_small();

    check("no_same_addr_rw", 64'(overlap), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
